// File: rtl/serial_cmp_pkg.sv
// Shared types and helpers for the MSB-first serializer and its comparator.
package serial_cmp_pkg;

  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} ser_state_e;

  function automatic int cnt_width(input int w);
    int c;
    c = $clog2(w);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/msb_first_shift_reg.sv
// Left-shifting operand register with parallel load and MSB tap.
module msb_first_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] q;

  // Zero fill on shift leaves the register clear once a word has drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= q << 1;
    end
  end

  assign msb = q[WIDTH-1];

endmodule

// File: rtl/serial_operand_serializer_msb_first.sv
// Serializes operand pairs MSB first with first/last framing; the last-bit cycle doubles as a reload slot.
module serial_operand_serializer_msb_first
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             ser_valid,
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_first,
  output logic             ser_last
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WIDTH - 1);

  ser_state_e       state;
  ser_state_e       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;
  logic             accept;
  logic             shift_en;
  logic             msb_a;
  logic             msb_b;

  assign last_bit = (state == ST_SHIFT) && (cnt == '0);
  assign in_ready = (state == ST_IDLE) || last_bit;
  assign accept   = in_valid && in_ready;
  assign shift_en = (state == ST_SHIFT) && !accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= CNT_TOP;
    end else if ((state == ST_SHIFT) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_SHIFT;
      ST_SHIFT: if (cnt == '0) state_nxt = accept ? ST_SHIFT : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  msb_first_shift_reg #(.WIDTH(WIDTH)) u_sr_a (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (shift_en),
    .din   (in_a),
    .msb   (msb_a)
  );

  msb_first_shift_reg #(.WIDTH(WIDTH)) u_sr_b (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (shift_en),
    .din   (in_b),
    .msb   (msb_b)
  );

  // Idle forces (0,0) so the downstream comparator stays in its equal state.
  always_comb begin
    ser_valid = (state == ST_SHIFT);
    ser_a     = ser_valid && msb_a;
    ser_b     = ser_valid && msb_b;
    ser_first = ser_valid && (cnt == CNT_TOP);
    ser_last  = last_bit;
  end

endmodule

// File: tb/tb_serial_operand_serializer_msb_first.sv
// Directed bench for the MSB-first serializer at WIDTH=8 and WIDTH=1 with a downstream comparator model.
module tb_serial_operand_serializer_msb_first;

  localparam logic [1:0] C_EQ = 2'd0;
  localparam logic [1:0] C_GT = 2'd1;
  localparam logic [1:0] C_LT = 2'd2;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid8, in_ready8;
  logic [7:0] in_a8, in_b8;
  logic       ser_valid8, ser_a8, ser_b8, ser_first8, ser_last8;
  logic       in_valid1, in_ready1;
  logic [0:0] in_a1, in_b1;
  logic       ser_valid1, ser_a1, ser_b1, ser_first1, ser_last1;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  serial_operand_serializer_msb_first #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .in_a      (in_a8),
    .in_b      (in_b8),
    .ser_valid (ser_valid8),
    .ser_a     (ser_a8),
    .ser_b     (ser_b8),
    .ser_first (ser_first8),
    .ser_last  (ser_last8)
  );

  serial_operand_serializer_msb_first #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .in_a      (in_a1),
    .in_b      (in_b1),
    .ser_valid (ser_valid1),
    .ser_a     (ser_a1),
    .ser_b     (ser_b1),
    .ser_first (ser_first1),
    .ser_last  (ser_last1)
  );

  // MSB-first comparator model, cleared by rst | ser_last.
  logic [1:0] cst8, cst1;

  function automatic logic [1:0] cres(input logic [1:0] c, input logic a, input logic b);
    if (c != C_EQ) return c;
    if (a && !b) return C_GT;
    if (!a && b) return C_LT;
    return C_EQ;
  endfunction

  always @(posedge clk) begin
    if (rst || ser_last8) cst8 <= C_EQ;
    else if (ser_valid8) cst8 <= cres(cst8, ser_a8, ser_b8);
    if (rst || ser_last1) cst1 <= C_EQ;
    else if (ser_valid1) cst1 <= cres(cst1, ser_a1, ser_b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered on the first-bit cycle; drives the next request during the last bit.
  task automatic emit_word(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                           input logic [1:0] ecmp, input logic nv, input logic [7:0] na,
                           input logic [7:0] nb, input logic noise);
    for (int i = 0; i < 8; i++) begin
      check({tag, "_valid"}, {31'd0, ser_valid8}, 32'd1);
      check({tag, "_a"},     {31'd0, ser_a8},     {31'd0, ea[7-i]});
      check({tag, "_b"},     {31'd0, ser_b8},     {31'd0, eb[7-i]});
      check({tag, "_first"}, {31'd0, ser_first8}, {31'd0, (i == 0)});
      check({tag, "_last"},  {31'd0, ser_last8},  {31'd0, (i == 7)});
      check({tag, "_ready"}, {31'd0, in_ready8},  {31'd0, (i == 7)});
      if (i == 7) begin
        check({tag, "_cmp"}, {30'd0, cres(cst8, ser_a8, ser_b8)}, {30'd0, ecmp});
        in_valid8 = nv;
        in_a8     = na;
        in_b8     = nb;
      end else if (noise) begin
        in_valid8 = 1'b1;
        in_a8     = 8'($urandom);
        in_b8     = 8'($urandom);
      end else begin
        in_valid8 = 1'b0;
      end
      tick();
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid8 = 1'b0;
    in_a8     = '0;
    in_b8     = '0;
    in_valid1 = 1'b0;
    in_a1     = '0;
    in_b1     = '0;
    tick();
    tick();
    check("rst_outs8", {28'd0, ser_valid8, ser_a8, ser_b8, ser_first8 | ser_last8}, 32'd0);
    check("rst_outs1", {28'd0, ser_valid1, ser_a1, ser_b1, ser_first1 | ser_last1}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle8", {28'd0, in_ready8, ser_valid8, ser_a8, ser_b8}, 32'h8);
      check("idle1", {28'd0, in_ready1, ser_valid1, ser_a1, ser_b1}, 32'h8);
    end

    // Single word.
    in_valid8 = 1'b1; in_a8 = 8'hA5; in_b8 = 8'hA3;
    tick();
    emit_word("single", 8'hA5, 8'hA3, C_GT, 1'b0, 8'h00, 8'h00, 1'b0);
    check("post_single", {30'd0, in_ready8, ser_valid8}, 32'h2);

    // Back-to-back pair with in_valid held high.
    in_valid8 = 1'b1; in_a8 = 8'h10; in_b8 = 8'h10;
    tick();
    emit_word("b2b_w0", 8'h10, 8'h10, C_EQ, 1'b1, 8'h0F, 8'hF0, 1'b0);
    emit_word("b2b_w1", 8'h0F, 8'hF0, C_LT, 1'b0, 8'h00, 8'h00, 1'b0);
    check("post_b2b", {30'd0, in_ready8, ser_valid8}, 32'h2);

    // Inputs wiggled while in_ready is low must not disturb the word.
    in_valid8 = 1'b1; in_a8 = 8'h5C; in_b8 = 8'h5D;
    tick();
    emit_word("noise", 8'h5C, 8'h5D, C_LT, 1'b0, 8'h00, 8'h00, 1'b1);

    // Abort mid-word with rst, then a fresh word.
    in_valid8 = 1'b1; in_a8 = 8'hC3; in_b8 = 8'h3C;
    tick();
    in_valid8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("abort_valid", {31'd0, ser_valid8}, 32'd1);
      check("abort_a", {31'd0, ser_a8}, {31'd0, (i < 2)});
      check("abort_last", {31'd0, ser_last8}, 32'd0);
      if (i == 2) rst = 1'b1;
      tick();
    end
    rst = 1'b0;
    check("abort_idle", {28'd0, in_ready8, ser_valid8, ser_a8, ser_last8}, 32'h8);
    check("abort_cmp_clr", {30'd0, cst8}, {30'd0, C_EQ});
    in_valid8 = 1'b1; in_a8 = 8'hFF; in_b8 = 8'h00;
    tick();
    emit_word("after_abort", 8'hFF, 8'h00, C_GT, 1'b0, 8'h00, 8'h00, 1'b0);

    // WIDTH=1 streaming.
    in_valid1 = 1'b1; in_a1 = 1'b1; in_b1 = 1'b0;
    tick();
    check("w1_p0_frame", {27'd0, in_ready1, ser_valid1, ser_first1, ser_last1, ser_a1}, 32'h1F);
    check("w1_p0_cmp", {30'd0, cres(cst1, ser_a1, ser_b1)}, {30'd0, C_GT});
    in_a1 = 1'b0; in_b1 = 1'b1;
    tick();
    check("w1_p1_frame", {27'd0, in_ready1, ser_valid1, ser_first1, ser_last1, ser_b1}, 32'h1F);
    check("w1_p1_cmp", {30'd0, cres(cst1, ser_a1, ser_b1)}, {30'd0, C_LT});
    in_a1 = 1'b1; in_b1 = 1'b1;
    tick();
    check("w1_p2_frame", {27'd0, in_ready1, ser_valid1, ser_first1, ser_last1, ser_a1}, 32'h1F);
    check("w1_p2_cmp", {30'd0, cres(cst1, ser_a1, ser_b1)}, {30'd0, C_EQ});
    in_valid1 = 1'b0;
    tick();
    check("w1_idle", {28'd0, in_ready1, ser_valid1, ser_a1, ser_b1}, 32'h8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
